// File: rtl/led_pwm_array.sv
// led_pwm_array: multi-channel PWM LED driver with one shared PWM counter,
// shadowed glitch-free level updates and steady/blink/breathe/off modes.
// Ports: clk, n_rst (async, active low), mode[1:0] (00 steady, 01 blink,
//   10 breathe, 11 off), level[NUM_CH*PWM_BITS] (channel i at
//   [i*PWM_BITS +: PWM_BITS]), update (capture strobe), led[NUM_CH]
//   (registered PWM outputs), frame_start (pulse at PWM period start).
// Build option: define LED_PWM_GAMMA_EN to apply a square-law gamma map
//   as levels move from pending to active; otherwise the map is linear.
module led_pwm_array #(
    parameter int          NUM_CH       = 3,
    parameter int          PWM_BITS     = 8,
    parameter logic [30:0] BLINK_PERIOD = 31'd13500000,
    parameter logic [15:0] BREATH_DIV   = 16'd4
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic [1:0]                 mode,
    input  logic [NUM_CH*PWM_BITS-1:0] level,
    input  logic                       update,
    output logic [NUM_CH-1:0]          led,
    output logic                       frame_start
);

    typedef enum logic [1:0] {
        MODE_STEADY  = 2'b00,
        MODE_BLINK   = 2'b01,
        MODE_BREATHE = 2'b10,
        MODE_OFF     = 2'b11
    } mode_t;

    localparam logic [PWM_BITS-1:0] P_MAX    = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'((1 << PWM_BITS) - 2);
    localparam logic [30:0]         BLINK_LAST = BLINK_PERIOD - 31'd1;
    localparam logic [15:0]         DIV_LAST   = BREATH_DIV - 16'd1;

    logic [PWM_BITS-1:0]   cnt;
    logic                  bnd;
    mode_t                 active_mode;
    mode_t                 mode_n;
    logic                  enter_blink;
    logic                  enter_breathe;

    logic [PWM_BITS-1:0]   pending [NUM_CH];
    logic [PWM_BITS-1:0]   active  [NUM_CH];
    logic [PWM_BITS-1:0]   src     [NUM_CH];
    logic [PWM_BITS-1:0]   act_n   [NUM_CH];
    logic [PWM_BITS-1:0]   eff     [NUM_CH];
    logic [2*PWM_BITS:0]   prod    [NUM_CH];
`ifdef LED_PWM_GAMMA_EN
    logic [2*PWM_BITS-1:0] sq      [NUM_CH];
`endif

    logic [30:0]           bcnt;
    logic [30:0]           bcnt_n;
    logic                  phase;
    logic                  phase_n;
    logic                  phase_q;

    logic [PWM_BITS-1:0]   env;
    logic [PWM_BITS-1:0]   env_n;
    logic                  dir_down;
    logic                  dir_n;
    logic [15:0]           bdiv;
    logic [15:0]           bdiv_n;

    // Mode register: only moves on the PWM boundary.
    always_comb begin
        bnd           = (cnt == CNT_LAST);
        mode_n        = active_mode;
        if (bnd) begin
            mode_n = mode_t'(mode);
        end
        enter_blink   = bnd && (mode_n == MODE_BLINK)
                            && (active_mode != MODE_BLINK);
        enter_breathe = bnd && (mode_n == MODE_BREATHE)
                            && (active_mode != MODE_BREATHE);
    end

    // Blink timer runs on raw clocks, independent of the PWM period.
    always_comb begin
        bcnt_n  = bcnt;
        phase_n = phase;
        if (enter_blink) begin
            bcnt_n  = '0;
            phase_n = 1'b1;
        end else if (active_mode == MODE_BLINK) begin
            if (bcnt == BLINK_LAST) begin
                bcnt_n  = '0;
                phase_n = ~phase;
            end else begin
                bcnt_n = bcnt + 31'd1;
            end
        end
    end

    // Breathe envelope: triangle, holding one step at each end.
    always_comb begin
        env_n  = env;
        dir_n  = dir_down;
        bdiv_n = bdiv;
        if (enter_breathe) begin
            env_n  = '0;
            dir_n  = 1'b0;
            bdiv_n = '0;
        end else if (bnd && (active_mode == MODE_BREATHE)) begin
            if (bdiv == DIV_LAST) begin
                bdiv_n = '0;
                if (!dir_down) begin
                    if (env == P_MAX) begin
                        dir_n = 1'b1;
                    end else begin
                        env_n = env + PWM_BITS'(1);
                    end
                end else begin
                    if (env == '0) begin
                        dir_n = 1'b0;
                    end else begin
                        env_n = env - PWM_BITS'(1);
                    end
                end
            end else begin
                bdiv_n = bdiv + 16'd1;
            end
        end
    end

    // An update on the boundary cycle bypasses pending straight to active.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            src[i] = update ? level[i*PWM_BITS +: PWM_BITS] : pending[i];
`ifdef LED_PWM_GAMMA_EN
            sq[i]    = (2*PWM_BITS)'(src[i])
                     * ((2*PWM_BITS)'(src[i]) + (2*PWM_BITS)'(1));
            act_n[i] = PWM_BITS'(sq[i] >> PWM_BITS);
`else
            act_n[i] = src[i];
`endif
        end
    end

    // eff depends only on state that changes at the boundary, so it is
    // constant for a whole PWM period; blink edges snap to periods.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            prod[i] = '0;
            eff[i]  = '0;
            unique case (active_mode)
                MODE_STEADY: eff[i] = active[i];
                MODE_BLINK:  eff[i] = phase_q ? active[i] : '0;
                MODE_BREATHE: begin
                    // active*(env+1) without widening env
                    prod[i] = (2*PWM_BITS+1)'(active[i])
                            * (2*PWM_BITS+1)'(env)
                            + (2*PWM_BITS+1)'(active[i]);
                    eff[i]  = PWM_BITS'(prod[i] >> PWM_BITS);
                end
                default:     eff[i] = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt         <= '0;
            active_mode <= MODE_OFF;
            bcnt        <= '0;
            phase       <= 1'b1;
            phase_q     <= 1'b1;
            env         <= '0;
            dir_down    <= 1'b0;
            bdiv        <= '0;
            led         <= '0;
            frame_start <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                pending[i] <= '0;
                active[i]  <= '0;
            end
        end else begin
            cnt         <= bnd ? '0 : cnt + PWM_BITS'(1);
            active_mode <= mode_n;
            bcnt        <= bcnt_n;
            phase       <= phase_n;
            env         <= env_n;
            dir_down    <= dir_n;
            bdiv        <= bdiv_n;
            frame_start <= (cnt == '0);
            if (bnd) begin
                phase_q <= phase_n;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                led[i] <= (cnt < eff[i]);
                if (update) begin
                    pending[i] <= level[i*PWM_BITS +: PWM_BITS];
                end
                if (bnd) begin
                    active[i] <= act_n[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_led_pwm_array.sv
// tb_led_pwm_array: directed bench for led_pwm_array.
// Measures per-period high counts aligned to frame_start.
module tb_led_pwm_array;

    localparam int FRAME = 255;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [1:0]  mode = 2'b11;
    logic [23:0] level = '0;
    logic        update = 1'b0;
    logic [2:0]  led;
    logic        frame_start;

    int n_vec = 0;
    int n_err = 0;
    int hi[3];
    int runs[3];
    int fs_bad;

    always #5 clk = ~clk;

    led_pwm_array #(
        .NUM_CH(3),
        .PWM_BITS(8),
        .BLINK_PERIOD(31'd1000),
        .BREATH_DIV(16'd1)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .mode(mode),
        .level(level),
        .update(update),
        .led(led),
        .frame_start(frame_start)
    );

    function automatic int gm(input int x);
`ifdef LED_PWM_GAMMA_EN
        return (x * (x + 1)) >> 8;
`else
        return x;
`endif
    endfunction

    // Sync to frame_start, then count 255 samples. Optional stimulus
    // injection after sample inj_at (DUT cnt is then inj_at+1).
    task automatic measure(input int inj_at, input logic [23:0] lv,
                           input logic [1:0] md);
        bit ok;
        logic [2:0] prev;
        ok = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge clk);
            ok = frame_start;
        end
        for (int c = 0; c < 3; c++) begin
            hi[c] = 0;
            runs[c] = 0;
        end
        fs_bad = 0;
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL frame_sync: no frame_start within 600 cycles");
            return;
        end
        prev = '0;
        for (int s = 0; s < FRAME; s++) begin
            if (s > 0) begin
                @(negedge clk);
                if (frame_start) fs_bad++;
            end
            for (int c = 0; c < 3; c++) begin
                if (led[c]) hi[c]++;
                if (led[c] && !prev[c]) runs[c]++;
            end
            prev = led;
            if (s == inj_at) begin
                level = lv;
                mode = md;
                update = 1'b1;
                @(posedge clk);
                #1 update = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (led !== 3'b000) begin
            n_err++;
            $display("FAIL reset_led: got %b want 000", led);
        end
        n_vec++;
        if (frame_start !== 1'b0) begin
            n_err++;
            $display("FAIL reset_fs: got %b want 0", frame_start);
        end
        n_rst = 1'b1;
    endtask

    task automatic test_steady;
        int e[3];
        measure(0, {8'hFF, 8'h80, 8'h00}, 2'b00);
        for (int c = 0; c < 3; c++) begin
            n_vec++;
            if (hi[c] !== 0) begin
                n_err++;
                $display("FAIL steady_off_frame ch%0d: got %0d want 0",
                         c, hi[c]);
            end
        end
        measure(-1, '0, 2'b00);
        e[0] = gm(8'h00);
        e[1] = gm(8'h80);
        e[2] = gm(8'hFF);
        for (int c = 0; c < 3; c++) begin
            n_vec++;
            if (hi[c] !== e[c]) begin
                n_err++;
                $display("FAIL steady_hi ch%0d: got %0d want %0d",
                         c, hi[c], e[c]);
            end
            n_vec++;
            if (runs[c] !== ((e[c] > 0) ? 1 : 0)) begin
                n_err++;
                $display("FAIL steady_runs ch%0d: got %0d", c, runs[c]);
            end
        end
        n_vec++;
        if (fs_bad !== 0) begin
            n_err++;
            $display("FAIL steady_fs_extra: got %0d want 0", fs_bad);
        end
        @(negedge clk);
        n_vec++;
        if (frame_start !== 1'b1) begin
            n_err++;
            $display("FAIL period_len: frame_start %b want 1", frame_start);
        end
    endtask

    task automatic test_mid_update;
        measure(10, {8'h00, 8'h00, 8'h40}, 2'b00);
        measure(100, {8'h00, 8'h00, 8'hC0}, 2'b00);
        n_vec++;
        if (hi[0] !== gm(8'h40)) begin
            n_err++;
            $display("FAIL mid_cur: got %0d want %0d", hi[0], gm(8'h40));
        end
        n_vec++;
        if (runs[0] !== 1) begin
            n_err++;
            $display("FAIL mid_runt: got %0d runs want 1", runs[0]);
        end
        measure(-1, '0, 2'b00);
        n_vec++;
        if (hi[0] !== gm(8'hC0)) begin
            n_err++;
            $display("FAIL mid_next: got %0d want %0d", hi[0], gm(8'hC0));
        end
        n_vec++;
        if (runs[0] !== 1) begin
            n_err++;
            $display("FAIL mid_next_runs: got %0d want 1", runs[0]);
        end
    endtask

    task automatic test_back_to_back;
        // update seen on the boundary cycle itself
        measure(253, {8'h20, 8'h20, 8'h20}, 2'b00);
        n_vec++;
        if (hi[0] !== gm(8'hC0)) begin
            n_err++;
            $display("FAIL b2b_old: got %0d want %0d", hi[0], gm(8'hC0));
        end
        // update one cycle after the boundary
        measure(254, {8'h60, 8'h60, 8'h60}, 2'b00);
        for (int c = 0; c < 3; c++) begin
            n_vec++;
            if (hi[c] !== gm(8'h20)) begin
                n_err++;
                $display("FAIL b2b_bypass ch%0d: got %0d want %0d",
                         c, hi[c], gm(8'h20));
            end
        end
        measure(-1, '0, 2'b00);
        n_vec++;
        if (hi[1] !== gm(8'h20)) begin
            n_err++;
            $display("FAIL b2b_late_hold: got %0d want %0d",
                     hi[1], gm(8'h20));
        end
        measure(-1, '0, 2'b00);
        n_vec++;
        if (hi[1] !== gm(8'h60)) begin
            n_err++;
            $display("FAIL b2b_late_new: got %0d want %0d",
                     hi[1], gm(8'h60));
        end
    endtask

    task automatic test_gamma;
        int e;
`ifdef LED_PWM_GAMMA_EN
        e = 64;
`else
        e = 128;
`endif
        measure(10, {8'h80, 8'h80, 8'h80}, 2'b00);
        measure(-1, '0, 2'b00);
        for (int c = 0; c < 3; c++) begin
            n_vec++;
            if (hi[c] !== e) begin
                n_err++;
                $display("FAIL gamma ch%0d: got %0d want %0d", c, hi[c], e);
            end
        end
    endtask

    task automatic test_blink;
        int e;
        measure(0, 24'hFFFFFF, 2'b01);
        // 1000-cycle phases quantised to 255-cycle periods: 4 on, 4 off
        for (int k = 0; k < 20; k++) begin
            measure(-1, '0, 2'b01);
            e = (((k / 4) % 2) == 0) ? 255 : 0;
            for (int c = 0; c < 3; c++) begin
                n_vec++;
                if (hi[c] !== e) begin
                    n_err++;
                    $display("FAIL blink k%0d ch%0d: got %0d want %0d",
                             k, c, hi[c], e);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge clk);
            ok = frame_start;
        end
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL rmid_sync: no frame_start");
        end
        repeat (49) @(negedge clk);
        n_vec++;
        if (led !== 3'b000) begin
            n_err++;
            $display("FAIL rmid_offphase: got %b want 000", led);
        end
        #2 n_rst = 1'b0;
        #1;
        n_vec++;
        if (led !== 3'b000 || frame_start !== 1'b0) begin
            n_err++;
            $display("FAIL rmid_async1: led %b fs %b want 000 0",
                     led, frame_start);
        end
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        measure(0, 24'hFFFFFF, 2'b01);
        for (int c = 0; c < 3; c++) begin
            n_vec++;
            if (hi[c] !== 0) begin
                n_err++;
                $display("FAIL rmid_offmode ch%0d: got %0d want 0",
                         c, hi[c]);
            end
        end
        measure(-1, '0, 2'b01);
        for (int c = 0; c < 3; c++) begin
            n_vec++;
            if (hi[c] !== 255) begin
                n_err++;
                $display("FAIL rmid_blink_on ch%0d: got %0d want 255",
                         c, hi[c]);
            end
        end
        @(negedge clk);
        n_vec++;
        if (led !== 3'b111 || frame_start !== 1'b1) begin
            n_err++;
            $display("FAIL rmid_pre: led %b fs %b want 111 1",
                     led, frame_start);
        end
        #2 n_rst = 1'b0;
        #1;
        n_vec++;
        if (led !== 3'b000 || frame_start !== 1'b0) begin
            n_err++;
            $display("FAIL rmid_async2: led %b fs %b want 000 0",
                     led, frame_start);
        end
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic test_breathe;
        int ev;
        int e;
        measure(0, {8'h00, 8'h00, 8'hFF}, 2'b10);
        n_vec++;
        if (hi[0] !== 0) begin
            n_err++;
            $display("FAIL breathe_offmode: got %0d want 0", hi[0]);
        end
        for (int k = 0; k < 258; k++) begin
            measure(-1, '0, 2'b10);
            if (k <= 255) ev = k;
            else if (k == 256) ev = 255;
            else ev = 254;
            e = (gm(255) * (ev + 1)) >> 8;
            n_vec++;
            if (hi[0] !== e) begin
                n_err++;
                $display("FAIL breathe k%0d: got %0d want %0d", k, hi[0], e);
            end
            n_vec++;
            if (hi[1] + hi[2] !== 0) begin
                n_err++;
                $display("FAIL breathe_zero k%0d: got %0d want 0",
                         k, hi[1] + hi[2]);
            end
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_steady();
        test_mid_update();
        test_back_to_back();
        test_gamma();
        test_blink();
        test_reset_mid();
        test_breathe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
